// File: rtl/rob_pkg.sv
// Shared parameters, index/count types and pointer arithmetic for the ROB commit controller.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int IDX_W     = 4;
  localparam int DISP_W    = 4;
  localparam int CMPL_W    = 6;
  localparam int RET_W     = 4;

  typedef logic [IDX_W-1:0] rob_idx_t;
  typedef logic [IDX_W:0]   rob_cnt_t;

  // Advances a ring pointer by count. The carry out of IDX_W bits is dropped,
  // so the pointer wraps modulo ROB_DEPTH.
  function automatic rob_idx_t rob_wrap_add(rob_idx_t base, rob_cnt_t count);
    return base + count[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Dispatch / completion / retire bundle between the ROB sequencer and its neighbours.
interface rob_commit_ctrl_if;
  import rob_pkg::*;

  logic                      i_flush;
  logic [2:0]                i_disp_count;
  logic                      o_disp_stall;
  rob_idx_t                  o_disp_base;
  rob_cnt_t                  o_free_slots;
  logic [CMPL_W-1:0]         i_cmpl_en;
  logic [CMPL_W*IDX_W-1:0]   i_cmpl_idx;
  logic [2:0]                o_ret_count;
  rob_idx_t                  o_ret_base;
  logic                      i_ret_ready;
  logic                      o_empty;
  logic                      o_full;
  logic                      o_err;

  // Pipeline side: drives dispatch, completion, retire-ready and flush.
  modport master (
    output i_flush, i_disp_count, i_cmpl_en, i_cmpl_idx, i_ret_ready,
    input  o_disp_stall, o_disp_base, o_free_slots, o_ret_count, o_ret_base,
           o_empty, o_full, o_err
  );

  // ROB sequencer side.
  modport slave (
    input  i_flush, i_disp_count, i_cmpl_en, i_cmpl_idx, i_ret_ready,
    output o_disp_stall, o_disp_base, o_free_slots, o_ret_count, o_ret_base,
           o_empty, o_full, o_err
  );
endinterface

// File: rtl/rob_ret_scan.sv
// Retire scan: length of the run of ready (valid & done) entries starting at head,
// walking the ring modulo ROB_DEPTH and capped at RET_W. Purely combinational.
module rob_ret_scan
  import rob_pkg::*;
(
  input  rob_idx_t             head_i,
  input  logic [ROB_DEPTH-1:0] ready_i,
  output logic [2:0]           count_o
);

  // Walk the head-rotated vector; the run stops at the first entry not ready.
  always_comb begin : scan_comb
    logic run;
    // NOTE: every combinational output gets a default before any branch, otherwise a latch is inferred.
    count_o = '0;
    run     = 1'b1;
    for (int k = 0; k < RET_W; k++) begin
      run = run & ready_i[rob_wrap_add(head_i, rob_cnt_t'(k))];
      if (run) count_o = count_o + 3'd1;
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB pointer and status sequencer: head/tail pointers, per-entry valid/done bits,
// occupancy, dispatch admission, completion marking and in-order retirement.
module rob_commit_ctrl
  import rob_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  rob_commit_ctrl_if.slave bus
);

  rob_idx_t             head_q, head_d;
  rob_idx_t             tail_q, tail_d;
  rob_cnt_t             occ_q, occ_d;
  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic                 err_q, err_d;

  rob_cnt_t   disp_cnt;
  rob_cnt_t   free_slots;
  logic [2:0] ret_count;
  logic       disp_stall;
  logic       disp_fire;
  logic       ret_fire;

  // Group sizes above DISP_W are treated as an empty group.
  assign disp_cnt   = (bus.i_disp_count > 3'(DISP_W)) ? '0 : rob_cnt_t'(bus.i_disp_count);
  // Space is judged on pre-edge occupancy; a same-cycle retire does not help.
  assign free_slots = rob_cnt_t'(ROB_DEPTH) - occ_q;
  assign disp_stall = disp_cnt > free_slots;
  assign disp_fire  = (disp_cnt != '0) && !disp_stall && !bus.i_flush;
  assign ret_fire   = bus.i_ret_ready && (ret_count != '0) && !bus.i_flush;

  rob_ret_scan u_ret_scan (
    .head_i  (head_q),
    .ready_i (valid_q & done_q),
    .count_o (ret_count)
  );

  // Next state: flush wipes everything; otherwise completion, then retire, then dispatch.
  // Retire clears after completion so a late duplicate completion cannot leave a stale done bit.
  always_comb begin : next_state_comb
    rob_idx_t idx;
    idx     = '0;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;
    if (bus.i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      occ_d   = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      // Completion is judged against pre-edge valid, so a slot allocated this edge flags an error.
      for (int p = 0; p < CMPL_W; p++) begin
        if (bus.i_cmpl_en[p]) begin
          idx = bus.i_cmpl_idx[IDX_W*p +: IDX_W];
          if (valid_q[idx]) done_d[idx] = 1'b1;
          else              err_d       = 1'b1;
        end
      end
      if (ret_fire) begin
        for (int k = 0; k < RET_W; k++) begin
          if (3'(k) < ret_count) begin
            idx          = rob_wrap_add(head_q, rob_cnt_t'(k));
            valid_d[idx] = 1'b0;
            done_d[idx]  = 1'b0;
          end
        end
        head_d = rob_wrap_add(head_q, rob_cnt_t'(ret_count));
      end
      if (disp_fire) begin
        for (int k = 0; k < DISP_W; k++) begin
          if (rob_cnt_t'(k) < disp_cnt) begin
            idx          = rob_wrap_add(tail_q, rob_cnt_t'(k));
            valid_d[idx] = 1'b1;
            done_d[idx]  = 1'b0;
          end
        end
        tail_d = rob_wrap_add(tail_q, disp_cnt);
      end
      occ_d = occ_q + (disp_fire ? disp_cnt : '0) - (ret_fire ? rob_cnt_t'(ret_count) : '0);
    end
  end

  // State registers with synchronous reset; the error flag survives flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the valid/done arrays are status flags, not payload storage, so they must be reset.
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      valid_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_disp_stall = disp_stall;
  assign bus.o_disp_base  = tail_q;
  assign bus.o_free_slots = free_slots;
  assign bus.o_ret_count  = ret_count;
  assign bus.o_ret_base   = head_q;
  assign bus.o_empty      = (occ_q == '0);
  assign bus.o_full       = (occ_q == rob_cnt_t'(ROB_DEPTH));
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed scenarios with a retire scoreboard.
module tb_rob_commit_ctrl;

  typedef struct {
    int cnt;
    int base;
  } ret_exp_t;

  logic i_clk = 1'b0;
  logic i_rst;

  ret_exp_t exp_q[$];
  int       n_tests = 0;
  int       n_fail  = 0;

  rob_commit_ctrl_if bus ();

  rob_commit_ctrl dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.i_flush      = 1'b0;
    bus.i_disp_count = '0;
    bus.i_cmpl_en    = '0;
    bus.i_cmpl_idx   = '0;
    bus.i_ret_ready  = 1'b0;
  endtask

  // Settle inputs, score any retirement the DUT is about to perform, then advance one cycle.
  task automatic tick();
    ret_exp_t e;
    #1;
    if (!i_rst && bus.i_ret_ready && !bus.i_flush && bus.o_ret_count != 0) begin
      if (exp_q.size() == 0) begin
        check("ret_unexpected", 32'(bus.o_ret_count), 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_ret_cnt",  32'(bus.o_ret_count), e.cnt);
        check("sb_ret_base", 32'(bus.o_ret_base),  e.base);
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic dispatch(input int n);
    bus.i_disp_count = 3'(n);
    tick();
    bus.i_disp_count = '0;
  endtask

  // Complete n consecutive ring entries from start, one per port, in one cycle.
  task automatic complete(input int start, input int n);
    bus.i_cmpl_en  = '0;
    bus.i_cmpl_idx = '0;
    for (int p = 0; p < n; p++) begin
      bus.i_cmpl_en[p]          = 1'b1;
      bus.i_cmpl_idx[4*p +: 4]  = 4'((start + p) % 16);
    end
    tick();
    bus.i_cmpl_en  = '0;
    bus.i_cmpl_idx = '0;
  endtask

  task automatic push_ret(input int cnt, input int base);
    ret_exp_t e;
    e.cnt  = cnt;
    e.base = base;
    exp_q.push_back(e);
  endtask

  initial begin
    // 1. Reset held two cycles under random inputs.
    i_rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.i_flush      = 1'($urandom);
      bus.i_disp_count = 3'($urandom_range(0, 7));
      bus.i_cmpl_en    = 6'($urandom);
      bus.i_cmpl_idx   = 24'($urandom);
      bus.i_ret_ready  = 1'($urandom);
      tick();
    end
    check("rst_free",      32'(bus.o_free_slots), 16);
    check("rst_empty",     32'(bus.o_empty),      1);
    check("rst_full",      32'(bus.o_full),       0);
    check("rst_ret_count", 32'(bus.o_ret_count),  0);
    check("rst_err",       32'(bus.o_err),        0);
    i_rst = 1'b0;
    idle();

    // 2. Dispatch 4, complete all, retire 4.
    bus.i_disp_count = 3'd4;
    #1;
    check("t2_stall", 32'(bus.o_disp_stall), 0);
    check("t2_base",  32'(bus.o_disp_base),  0);
    tick();
    bus.i_disp_count = '0;
    check("t2_free_after_disp", 32'(bus.o_free_slots), 12);
    bus.i_cmpl_en    = 6'b001111;
    bus.i_cmpl_idx   = 24'h003210;
    bus.i_ret_ready  = 1'b1;
    push_ret(4, 0);
    tick();
    bus.i_cmpl_en    = '0;
    check("t2_ret_count", 32'(bus.o_ret_count), 4);
    check("t2_ret_base",  32'(bus.o_ret_base),  0);
    tick();
    check("t2_head",  32'(bus.o_ret_base),   4);
    check("t2_free",  32'(bus.o_free_slots), 16);
    check("t2_empty", 32'(bus.o_empty),      1);

    // 3. Out-of-order completion blocks retirement until the head completes.
    dispatch(3);
    complete(5, 2);
    check("t3_ret_blocked", 32'(bus.o_ret_count), 0);
    push_ret(3, 4);
    complete(4, 1);
    check("t3_ret_count", 32'(bus.o_ret_count), 3);
    tick();
    check("t3_empty", 32'(bus.o_empty),    1);
    check("t3_head",  32'(bus.o_ret_base), 7);
    bus.i_ret_ready = 1'b0;

    // 4. Fill to full, stall, then retire with a rejected same-cycle dispatch.
    for (int g = 0; g < 4; g++) dispatch(4);
    check("t4_full", 32'(bus.o_full),       1);
    check("t4_free", 32'(bus.o_free_slots), 0);
    bus.i_disp_count = 3'd1;
    #1;
    check("t4_stall", 32'(bus.o_disp_stall), 1);
    tick();
    bus.i_disp_count = '0;
    check("t4_tail_held", 32'(bus.o_disp_base), 7);
    complete(7, 6);
    check("t4_ret_capped", 32'(bus.o_ret_count), 4);
    bus.i_ret_ready  = 1'b1;
    bus.i_disp_count = 3'd1;
    push_ret(4, 7);
    #1;
    check("t4_stall_retire", 32'(bus.o_disp_stall), 1);
    tick();
    bus.i_ret_ready  = 1'b0;
    bus.i_disp_count = '0;
    check("t4_free_after_ret", 32'(bus.o_free_slots), 4);
    check("t4_head",           32'(bus.o_ret_base),   11);
    check("t4_tail",           32'(bus.o_disp_base),  7);

    // Flush, then march head/tail to 14 through a scored drain.
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    check("t4_flush_empty", 32'(bus.o_empty), 1);
    dispatch(4); dispatch(4); dispatch(4); dispatch(2);
    complete(0, 6); complete(6, 6); complete(12, 2);
    bus.i_ret_ready = 1'b1;
    push_ret(4, 0); push_ret(4, 4); push_ret(4, 8); push_ret(2, 12);
    for (int r = 0; r < 4; r++) tick();
    bus.i_ret_ready = 1'b0;
    check("t4_drain_empty", 32'(bus.o_empty),     1);
    check("t4_drain_head",  32'(bus.o_ret_base),  14);
    check("t4_drain_tail",  32'(bus.o_disp_base), 14);

    // 5. Wrap-around dispatch/retire, with duplicate completion indices.
    dispatch(4);
    check("t5_ret_none", 32'(bus.o_ret_count), 0);
    bus.i_cmpl_en  = 6'b111111;
    bus.i_cmpl_idx = {4'd1, 4'd14, 4'd1, 4'd0, 4'd15, 4'd14};
    tick();
    bus.i_cmpl_en  = '0;
    check("t5_ret_count", 32'(bus.o_ret_count), 4);
    check("t5_ret_base",  32'(bus.o_ret_base),  14);
    check("t5_dup_err",   32'(bus.o_err),       0);
    bus.i_ret_ready = 1'b1;
    push_ret(4, 14);
    tick();
    bus.i_ret_ready = 1'b0;
    check("t5_head",  32'(bus.o_ret_base), 2);
    check("t5_empty", 32'(bus.o_empty),    1);

    // Oversized group is an empty group.
    bus.i_disp_count = 3'd5;
    #1;
    check("ovr_stall", 32'(bus.o_disp_stall), 0);
    tick();
    bus.i_disp_count = '0;
    check("ovr_free", 32'(bus.o_free_slots), 16);

    // 6. Flush with 7 occupied plus same-cycle dispatch and completion.
    dispatch(4);
    dispatch(3);
    check("t6_free", 32'(bus.o_free_slots), 9);
    bus.i_flush      = 1'b1;
    bus.i_disp_count = 3'd2;
    bus.i_cmpl_en    = 6'b000001;
    bus.i_cmpl_idx   = 24'h000002;
    bus.i_ret_ready  = 1'b1;
    tick();
    idle();
    check("t6_empty", 32'(bus.o_empty),      1);
    check("t6_free2", 32'(bus.o_free_slots), 16);
    check("t6_head",  32'(bus.o_ret_base),   0);
    check("t6_tail",  32'(bus.o_disp_base),  0);
    check("t6_err0",  32'(bus.o_err),        0);
    complete(5, 1);
    check("t6_err_set", 32'(bus.o_err), 1);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    check("t6_err_sticky", 32'(bus.o_err), 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("t6_err_rst", 32'(bus.o_err), 0);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
